zigzag_scan: RTL and testbench

Generates the zigzag scan order of a COL×ROW coefficient block as (x, y) coordinate pairs, one pair per clock. It sits between the transform/quantisation buffer and the entropy coder. It supplies read addresses into the block buffer after a one-cycle `start` pulse, and flags the final coordinate with `done`.

---
 rtl/zigzag_pkg.sv | 15 +
 rtl/zigzag_scan.sv | 121 ++++++++++++
 tb/tb_zigzag_scan.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/zigzag_pkg.sv
// Shared types for the zigzag coefficient scan generator.
// State and scan-direction encodings used by zigzag_scan.
package zigzag_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/zigzag_scan.sv
// Zigzag scan address generator: emits one (x, y) coordinate of a
// COL x ROW block per clock after a start pulse, flagging the last one.
module zigzag_scan
  import zigzag_pkg::*;
#(
  parameter int COL = 8,
  parameter int ROW = 8,
  localparam int XW = $clog2(COL),
  localparam int YW = $clog2(ROW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          done,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          valid
);

  localparam logic [XW-1:0] XMAX = XW'(COL - 1);
  localparam logic [YW-1:0] YMAX = YW'(ROW - 1);

  state_e        state_q;
  dir_e          dir_q;
  dir_e          dir_d;
  logic [XW-1:0] x_q;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_q;
  logic [YW-1:0] y_d;
  logic          valid_q;
  logic          done_q;
  logic          done_d;
  logic          last;

  assign x     = x_q;
  assign y     = y_q;
  assign valid = valid_q;
  assign done  = done_q;

  assign last = (x_q == XMAX) && (y_q == YMAX);

  // Edge tests run in priority order so corners of
  // non-square blocks pick the right turn.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    dir_d = dir_q;
    unique case (dir_q)
      UP: begin
        if (x_q == XMAX) begin
          y_d   = y_q + 1'b1;
          dir_d = DOWN;
        end else if (y_q == '0) begin
          x_d   = x_q + 1'b1;
          dir_d = DOWN;
        end else begin
          x_d = x_q + 1'b1;
          y_d = y_q - 1'b1;
        end
      end
      DOWN: begin
        if (y_q == YMAX) begin
          x_d   = x_q + 1'b1;
          dir_d = UP;
        end else if (x_q == '0) begin
          y_d   = y_q + 1'b1;
          dir_d = UP;
        end else begin
          x_d = x_q - 1'b1;
          y_d = y_q + 1'b1;
        end
      end
    endcase
  end

  assign done_d = (x_d == XMAX) && (y_d == YMAX);

  // rst_n asserts high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      dir_q   <= UP;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          x_q    <= '0;
          y_q    <= '0;
          dir_q  <= UP;
          done_q <= 1'b0;
          if (start) begin
            state_q <= SCAN;
            valid_q <= 1'b1;
          end else begin
            valid_q <= 1'b0;
          end
        end
        SCAN: begin
          if (last) begin
            state_q <= IDLE;
            dir_q   <= UP;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            dir_q   <= dir_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= 1'b1;
            done_q  <= done_d;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zigzag_scan.sv
// Bench for zigzag_scan: diagonal-enumeration reference model checked
// every cycle on an 8x8 and a 4x2 instance, plus literal sequence pins.
module tb_zigzag_scan;

  typedef struct {
    int x;
    int y;
  } pt_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] x8;
  logic [2:0] y8;
  logic       v8;
  logic       d8;
  logic [1:0] x42;
  logic [0:0] y42;
  logic       v42;
  logic       d42;

  always #5 clk = ~clk;

  zigzag_scan #(.COL(8), .ROW(8)) u_dut8 (
    .clk(clk), .rst_n(rst), .start(start),
    .done(d8), .x(x8), .y(y8), .valid(v8)
  );

  zigzag_scan #(.COL(4), .ROW(2)) u_dut42 (
    .clk(clk), .rst_n(rst), .start(start),
    .done(d42), .x(x42), .y(y42), .valid(v42)
  );

  int vecs = 0;
  int errs = 0;

  // k-th cell of the zigzag order, found by walking anti-diagonals:
  // even diagonals run up-right, odd ones run down-left.
  function automatic pt_t zz(input int c, input int r, input int k);
    pt_t p;
    int  n;
    int  xx;
    int  yy;
    p = '{0, 0};
    n = 0;
    for (int s = 0; s <= c + r - 2; s++) begin
      for (int i = 0; i < c + r; i++) begin
        if (s % 2 == 0) begin
          yy = ((s < r - 1) ? s : r - 1) - i;
          xx = s - yy;
        end else begin
          xx = ((s < c - 1) ? s : c - 1) - i;
          yy = s - xx;
        end
        if (xx >= 0 && xx < c && yy >= 0 && yy < r) begin
          if (n == k) p = '{xx, yy};
          n++;
        end
      end
    end
    return p;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference scan progress: busy flag and position in the scan order.
  bit busy8 = 1'b0;
  bit busy42 = 1'b0;
  int idx8 = 0;
  int idx42 = 0;

  always @(posedge clk) begin
    if (rst) begin
      busy8 <= 1'b0;
      idx8  <= 0;
    end else if (busy8) begin
      if (idx8 == 63) busy8 <= 1'b0;
      else idx8 <= idx8 + 1;
    end else if (start) begin
      busy8 <= 1'b1;
      idx8  <= 0;
    end
    if (rst) begin
      busy42 <= 1'b0;
      idx42  <= 0;
    end else if (busy42) begin
      if (idx42 == 7) busy42 <= 1'b0;
      else idx42 <= idx42 + 1;
    end else if (start) begin
      busy42 <= 1'b1;
      idx42  <= 0;
    end
  end

  pt_t q8[$];
  pt_t q42[$];
  int  done8 = 0;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    fork
      begin : stim
        int ex8[20];
        int ex42[16];
        int base;
        int b42;
        int uniq;
        bit seen[64];
        pt_t p;
        ex8  = '{0,0, 1,0, 0,1, 0,2, 1,1, 2,0, 3,0, 2,1, 1,2, 0,3};
        ex42 = '{0,0, 1,0, 0,1, 1,1, 2,0, 3,0, 2,1, 3,1};
        for (int k = 0; k < 10; k++) begin
          p = zz(8, 8, k);
          chk("model8_x", p.x, ex8[2*k]);
          chk("model8_y", p.y, ex8[2*k+1]);
        end
        for (int k = 0; k < 8; k++) begin
          p = zz(4, 2, k);
          chk("model42_x", p.x, ex42[2*k]);
          chk("model42_y", p.y, ex42[2*k+1]);
        end
        p = zz(8, 8, 63);
        chk("model8_last", p.x * 8 + p.y, 63);

        rst = 1'b1;
        cyc(3);
        chk("rst_x", int'(x8), 0);
        chk("rst_y", int'(y8), 0);
        chk("rst_valid", int'(v8), 0);
        chk("rst_done", int'(d8), 0);
        rst = 1'b0;
        cyc(5);
        chk("idle_valid", int'(v8), 0);

        base = q8.size();
        b42 = q42.size();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("lat_valid", int'(v8), 1);
        chk("lat_x", int'(x8), 0);
        chk("lat_y", int'(y8), 0);
        cyc(70);
        chk("count8", q8.size() - base, 64);
        chk("count42", q42.size() - b42, 8);
        for (int k = 0; k < 10; k++) begin
          chk("seq8_x", q8[base+k].x, ex8[2*k]);
          chk("seq8_y", q8[base+k].y, ex8[2*k+1]);
        end
        for (int k = 0; k < 8; k++) begin
          chk("seq42_x", q42[b42+k].x, ex42[2*k]);
          chk("seq42_y", q42[b42+k].y, ex42[2*k+1]);
        end
        uniq = 0;
        for (int k = 0; k < 64; k++) seen[k] = 1'b0;
        for (int k = 0; k < 64 && base + k < q8.size(); k++) begin
          if (!seen[q8[base+k].y*8 + q8[base+k].x]) uniq++;
          seen[q8[base+k].y*8 + q8[base+k].x] = 1'b1;
        end
        chk("unique8", uniq, 64);
        chk("done8_a", done8, 1);

        base = q8.size();
        start = 1'b1;
        cyc(70);
        start = 1'b0;
        cyc(70);
        chk("count8_held", q8.size() - base, 128);
        if (q8.size() > base + 64) begin
          chk("restart_x", q8[base+64].x, 0);
          chk("restart_y", q8[base+64].y, 0);
        end else begin
          chk("restart_present", q8.size() - base, 65);
        end
        chk("done8_b", done8, 3);

        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(19);
        chk("abort_pre_valid", int'(v8), 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("abort_valid", int'(v8), 0);
        chk("abort_done", int'(d8), 0);
        cyc(3);
        chk("done8_c", done8, 3);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("re_valid", int'(v8), 1);
        chk("re_x", int'(x8), 0);
        chk("re_y", int'(y8), 0);
        cyc(70);
        chk("done8_d", done8, 4);
      end
      begin : cmp
        forever begin
          @(negedge clk);
          begin
            pt_t e;
            e = busy8 ? zz(8, 8, idx8) : '{0, 0};
            chk("x8", int'(x8), e.x);
            chk("y8", int'(y8), e.y);
            chk("valid8", int'(v8), int'(busy8));
            chk("done8", int'(d8), int'(busy8 && idx8 == 63));
            e = busy42 ? zz(4, 2, idx42) : '{0, 0};
            chk("x42", int'(x42), e.x);
            chk("y42", int'(y42), e.y);
            chk("valid42", int'(v42), int'(busy42));
            chk("done42", int'(d42), int'(busy42 && idx42 == 7));
            if (v8) q8.push_back('{int'(x8), int'(y8)});
            if (v42) q42.push_back('{int'(x42), int'(y42)});
            if (d8) done8++;
          end
        end
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
